// File: rtl/fht_pkg.sv
// Shared definitions for the FHT I/O path: sequencer state encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fht_pkg;

    localparam int FHT_D_BIT     = 16;
    localparam int FHT_A_BIT     = 8;
    localparam int FHT_BANK_SIZE = 2 ** FHT_A_BIT;
    localparam int FHT_N         = 4 * FHT_BANK_SIZE;
    localparam int FHT_START_TO  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT_BUSY,
        ST_WAIT_RDY,
        ST_UNLOAD,
        ST_DRAIN
    } fht_state_t;

endpackage

// File: rtl/fht_skid_fifo.sv
// Two-entry FIFO holding bank read results ahead of the output stream.
// Latency: a push is visible at the head one cycle later; head is a plain register read.
// Backpressure: pop is ignored when empty; push on full is only taken together with a pop.
module fht_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop & ~empty;
    // When full, the slot being written is the one popped this same cycle.
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fht_io_sequencer.sv
// Loads N samples round-robin into four banks, kicks the FHT core, then streams results back out.
// Latency: writes land the cycle a sample is accepted; results appear two cycles after their read issues.
// Backpressure: input held off outside LOAD; reads throttled so at most two results are ever buffered.
module fht_io_sequencer
    import fht_pkg::*;
#(
    parameter int D_BIT    = FHT_D_BIT,
    parameter int A_BIT    = FHT_A_BIT,
    parameter int START_TO = FHT_START_TO
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oSTART,
    input  logic             iRDY,
    output logic [A_BIT-1:0] oADDR,
    output logic [D_BIT-1:0] oWDATA,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    input  logic [D_BIT-1:0] iRDATA_0,
    input  logic [D_BIT-1:0] iRDATA_1,
    input  logic [D_BIT-1:0] iRDATA_2,
    input  logic [D_BIT-1:0] iRDATA_3,
    output logic             oBUSY,
    output logic             oERR
);

    localparam int TW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [TW-1:0]    TO_LAST  = TW'(START_TO - 1);
    // N is a power of two, so the last sample/result index is all ones.
    localparam logic [A_BIT+1:0] IDX_LAST = '1;

    fht_state_t       state, state_nxt;
    logic [A_BIT+1:0] idx;
    logic [TW-1:0]    to_cnt;
    logic             err_q;
    logic             rd_inflight;
    logic [1:0]       rd_bank;

    logic             acc;
    logic             issue;
    logic             timeout;
    logic             pop_fire;
    logic             room_ok;
    logic [1:0]       fifo_occ;
    logic             fifo_full;
    logic             fifo_empty;
    logic [D_BIT-1:0] rd_dat;

    assign acc      = (state == ST_LOAD) & iVALID;
    assign timeout  = (state == ST_WAIT_BUSY) & iRDY & (to_cnt == TO_LAST);
    assign oVALID   = ~fifo_empty;
    assign pop_fire = oVALID & iREADY;
    assign fifo_occ = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    // A pop this cycle frees a slot in time for the read issued now, which keeps one result per cycle.
    assign room_ok  = ({1'b0, fifo_occ} + {2'b0, rd_inflight}) < (3'd2 + {2'b0, pop_fire});
    assign issue    = (state == ST_UNLOAD) & room_ok;
    assign oERR     = err_q;

    // State register.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and bank/control port drive.
    always_comb begin
        state_nxt = state;
        oREADY    = 1'b0;
        oSTART    = 1'b0;
        oBUSY     = (state != ST_IDLE);
        oADDR     = '0;
        oWDATA    = '0;
        oWE_0     = 1'b0;
        oWE_1     = 1'b0;
        oWE_2     = 1'b0;
        oWE_3     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (iVALID) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                oREADY = 1'b1;
                if (acc) begin
                    oADDR  = idx[A_BIT+1:2];
                    oWDATA = iDATA;
                    oWE_0  = (idx[1:0] == 2'd0);
                    oWE_1  = (idx[1:0] == 2'd1);
                    oWE_2  = (idx[1:0] == 2'd2);
                    oWE_3  = (idx[1:0] == 2'd3);
                    if (idx == IDX_LAST) state_nxt = ST_KICK;
                end
            end
            ST_KICK: begin
                oSTART    = 1'b1;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!iRDY)        state_nxt = ST_WAIT_RDY;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_WAIT_RDY: begin
                if (iRDY) state_nxt = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                if (issue) begin
                    oADDR = idx[A_BIT+1:2];
                    if (idx == IDX_LAST) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !rd_inflight) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sample/result index, start timeout counter, sticky error and read pipeline tracking.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            idx         <= '0;
            to_cnt      <= '0;
            err_q       <= 1'b0;
            rd_inflight <= 1'b0;
            rd_bank     <= 2'd0;
        end else begin
            if (state == ST_IDLE || state == ST_WAIT_RDY) begin
                idx <= '0;
            end else if (acc || issue) begin
                idx <= idx + 1'b1;
            end

            if (state != ST_WAIT_BUSY) begin
                to_cnt <= '0;
            end else if (iRDY) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout) begin
                err_q <= 1'b1;
            end else if (state == ST_IDLE && iVALID) begin
                err_q <= 1'b0;
            end

            rd_inflight <= issue;
            if (issue) begin
                rd_bank <= idx[1:0];
            end
        end
    end

    // Select the bank addressed by the read issued last cycle.
    always_comb begin
        rd_dat = iRDATA_0;
        unique case (rd_bank)
            2'd0: rd_dat = iRDATA_0;
            2'd1: rd_dat = iRDATA_1;
            2'd2: rd_dat = iRDATA_2;
            2'd3: rd_dat = iRDATA_3;
            default: rd_dat = iRDATA_0;
        endcase
    end

    fht_skid_fifo #(
        .W (D_BIT)
    ) u_out_fifo (
        .clk      (iCLK),
        .rst_n    (iRESET),
        .push     (rd_inflight),
        .push_dat (rd_dat),
        .pop      (iREADY),
        .pop_dat  (oDATA),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_fht_io_sequencer.sv
// Bench for fht_io_sequencer: bank memory and FHT-control models, queue scoreboard for writes and results.
// Latency: n/a.
// Backpressure: random sink stalls during unload.
`timescale 1ns/1ps
module tb_fht_io_sequencer;

    localparam int D_BIT    = 16;
    localparam int A_BIT    = 8;
    localparam int N        = 4 * (2 ** A_BIT);
    localparam int START_TO = 4;

    logic             iCLK   = 1'b0;
    logic             iRESET = 1'b1;
    logic [D_BIT-1:0] iDATA;
    logic             iVALID;
    logic             oREADY;
    logic [D_BIT-1:0] oDATA;
    logic             oVALID;
    logic             iREADY = 1'b1;
    logic             oSTART;
    logic             iRDY;
    logic [A_BIT-1:0] oADDR;
    logic [D_BIT-1:0] oWDATA;
    logic             oWE_0, oWE_1, oWE_2, oWE_3;
    logic [D_BIT-1:0] iRDATA_0, iRDATA_1, iRDATA_2, iRDATA_3;
    logic             oBUSY;
    logic             oERR;

    fht_io_sequencer #(
        .D_BIT    (D_BIT),
        .A_BIT    (A_BIT),
        .START_TO (START_TO)
    ) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iDATA    (iDATA),
        .iVALID   (iVALID),
        .oREADY   (oREADY),
        .oDATA    (oDATA),
        .oVALID   (oVALID),
        .iREADY   (iREADY),
        .oSTART   (oSTART),
        .iRDY     (iRDY),
        .oADDR    (oADDR),
        .oWDATA   (oWDATA),
        .oWE_0    (oWE_0),
        .oWE_1    (oWE_1),
        .oWE_2    (oWE_2),
        .oWE_3    (oWE_3),
        .iRDATA_0 (iRDATA_0),
        .iRDATA_1 (iRDATA_1),
        .iRDATA_2 (iRDATA_2),
        .iRDATA_3 (iRDATA_3),
        .oBUSY    (oBUSY),
        .oERR     (oERR)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [1:0]       bank;
        logic [A_BIT-1:0] addr;
        logic [D_BIT-1:0] dat;
    } wr_t;

    wr_t              wr_exp [$];
    logic [D_BIT-1:0] res_exp [$];
    int               checks    = 0;
    int               errors    = 0;
    int               n_res     = 0;
    int               start_cnt = 0;
    bit               rand_rdy  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, required none", name);
    endtask

    // Four banks with one-cycle registered read, as seen by the sequencer.
    logic [D_BIT-1:0] bank [4][2**A_BIT];
    always @(posedge iCLK) begin
        if (oWE_0) bank[0][oADDR] <= oWDATA;
        if (oWE_1) bank[1][oADDR] <= oWDATA;
        if (oWE_2) bank[2][oADDR] <= oWDATA;
        if (oWE_3) bank[3][oADDR] <= oWDATA;
        iRDATA_0 <= bank[0][oADDR];
        iRDATA_1 <= bank[1][oADDR];
        iRDATA_2 <= bank[2][oADDR];
        iRDATA_3 <= bank[3][oADDR];
    end

    // Sink: always ready, or a coin flip each cycle.
    initial begin
        forever begin
            @(posedge iCLK);
            #1;
            iREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: bank writes, result stream, stall stability, start pulses.
    logic [D_BIT-1:0] held;
    bit               held_vld = 1'b0;
    always @(negedge iCLK) begin
        logic [3:0] we;
        wr_t        w;
        we = {oWE_3, oWE_2, oWE_1, oWE_0};
        if (!iRESET) begin
            held_vld = 1'b0;
        end else begin
            if (iVALID && oREADY) begin
                if (wr_exp.size() == 0) begin
                    fail("write_without_sample");
                end else begin
                    w = wr_exp.pop_front();
                    chk("wr_enable", 64'(we), 64'(4'b0001 << w.bank));
                    chk("wr_addr", 64'(oADDR), 64'(w.addr));
                    chk("wr_data", 64'(oWDATA), 64'(w.dat));
                end
            end else if (we != 4'b0000) begin
                chk("wr_without_accept", 64'(we), 64'd0);
            end
            if (oSTART) start_cnt++;
            if (held_vld) chk("stall_stable", 64'({oVALID, oDATA}), 64'({1'b1, held}));
            held_vld = 1'b0;
            if (oVALID && iREADY) begin
                n_res++;
                if (res_exp.size() == 0) fail("result_unexpected");
                else chk("result", 64'(oDATA), 64'(res_exp.pop_front()));
            end else if (oVALID) begin
                held     = oDATA;
                held_vld = 1'b1;
            end
        end
    end

    // Stream one frame; each sample's bank write and eventual result go on the scoreboard.
    task automatic load_frame(input bit rnd_data, input bit toggle, input bit rdy_noise, input int stop_at);
        for (int k = 0; k < N; k++) begin
            logic [D_BIT-1:0] v;
            bit               accepted;
            int               guard;
            if (k == stop_at) return;
            if (toggle && k > 0) begin
                iVALID = 1'b0;
                if (rdy_noise) iRDY = 1'($urandom_range(0, 1));
                @(posedge iCLK);
                #1;
            end
            v      = rnd_data ? D_BIT'($urandom) : D_BIT'(k);
            iDATA  = v;
            iVALID = 1'b1;
            if (rdy_noise) iRDY = 1'($urandom_range(0, 1));
            wr_exp.push_back('{bank: 2'(k % 4), addr: A_BIT'(k / 4), dat: v});
            res_exp.push_back(v);
            accepted = 1'b0;
            guard    = 0;
            while (!accepted) begin
                @(negedge iCLK);
                accepted = oREADY;
                @(posedge iCLK);
                #1;
                guard++;
                if (guard > 20) begin
                    $display("FAIL load_accept_timeout: sample %0d not accepted in 20 cycles", k);
                    $fatal(1, "load stalled");
                end
            end
        end
        iVALID = 1'b0;
        iRDY   = 1'b1;
    endtask

    // Called in the cycle after the last accept; plays the FHT control block.
    task automatic kick_and_control(input bit hold_rdy);
        @(negedge iCLK);
        chk("start_after_last", 64'(oSTART), 64'd1);
        chk("ready_low_after_last", 64'(oREADY), 64'd0);
        @(posedge iCLK);
        #1;
        if (!hold_rdy) begin
            @(negedge iCLK);
            chk("start_single_cycle", 64'(oSTART), 64'd0);
            @(posedge iCLK);
            #1;
            iRDY = 1'b0;
            repeat (300) @(posedge iCLK);
            #1;
            iRDY = 1'b1;
        end else begin
            for (int i = 1; i <= START_TO; i++) begin
                @(negedge iCLK);
                chk("err_not_yet", 64'(oERR), 64'd0);
                chk("busy_waiting", 64'(oBUSY), 64'd1);
                @(posedge iCLK);
                #1;
            end
            @(negedge iCLK);
            chk("err_on_timeout", 64'(oERR), 64'd1);
            chk("idle_after_timeout", 64'(oBUSY), 64'd0);
        end
    endtask

    task automatic wait_done(input bit check_rate);
        int cyc;
        cyc = 0;
        while ((oBUSY || res_exp.size() != 0) && cyc < 20000) begin
            @(posedge iCLK);
            #1;
            cyc++;
        end
        if (cyc >= 20000) fail("unload_timeout");
        chk("results_outstanding", 64'(res_exp.size()), 64'd0);
        if (check_rate) chk("unload_rate", 64'(cyc >= N && cyc <= N + 6), 64'd1);
    endtask

    task automatic run_frame(input bit rnd_data, input bit toggle, input bit noise, input bit rr, input bit rate);
        n_res     = 0;
        start_cnt = 0;
        rand_rdy  = rr;
        load_frame(rnd_data, toggle, noise, -1);
        kick_and_control(1'b0);
        wait_done(rate);
        chk("result_count", 64'(n_res), 64'(N));
        chk("start_pulses", 64'(start_cnt), 64'd1);
        chk("writes_outstanding", 64'(wr_exp.size()), 64'd0);
        rand_rdy = 1'b0;
    endtask

    initial begin
        iVALID = 1'b0;
        iDATA  = '0;
        iRDY   = 1'b1;
        #3 iRESET = 1'b0;
        #2;
        chk("rst_ready", 64'(oREADY), 64'd0);
        chk("rst_valid", 64'(oVALID), 64'd0);
        chk("rst_start", 64'(oSTART), 64'd0);
        chk("rst_we", 64'({oWE_3, oWE_2, oWE_1, oWE_0}), 64'd0);
        chk("rst_busy", 64'(oBUSY), 64'd0);
        chk("rst_err", 64'(oERR), 64'd0);
        chk("rst_addr", 64'(oADDR), 64'd0);
        chk("rst_wdata", 64'(oWDATA), 64'd0);
        chk("rst_data", 64'(oDATA), 64'd0);
        @(posedge iCLK);
        #1;
        iRESET = 1'b1;
        repeat (2) @(posedge iCLK);
        #1;

        // value = index, sink always ready, full-rate unload.
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // random data, gappy input, iRDY noise during load, random sink stalls.
        run_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // FHT core never goes busy: timeout, no unload.
        n_res = 0;
        load_frame(1'b1, 1'b0, 1'b0, -1);
        kick_and_control(1'b1);
        repeat (10) @(posedge iCLK);
        #1;
        chk("no_results_after_timeout", 64'(n_res), 64'd0);
        chk("no_valid_after_timeout", 64'(oVALID), 64'd0);
        res_exp.delete();
        chk("err_sticky_idle", 64'(oERR), 64'd1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("err_cleared_by_new_frame", 64'(oERR), 64'd0);

        // Reset in the middle of a load.
        load_frame(1'b1, 1'b0, 1'b0, 500);
        iRESET = 1'b0;
        #1;
        chk("midrst_ready", 64'(oREADY), 64'd0);
        chk("midrst_busy", 64'(oBUSY), 64'd0);
        chk("midrst_we", 64'({oWE_3, oWE_2, oWE_1, oWE_0}), 64'd0);
        chk("midrst_addr", 64'(oADDR), 64'd0);
        chk("midrst_wdata", 64'(oWDATA), 64'd0);
        chk("midrst_valid", 64'(oVALID), 64'd0);
        iVALID = 1'b0;
        wr_exp.delete();
        res_exp.delete();
        @(posedge iCLK);
        #1;
        iRESET = 1'b1;
        @(posedge iCLK);
        #1;
        run_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fht_io_sequencer.md
FHT_IO_SEQUENCER -- requirements
Module: fht_io_sequencer

Interface
REQ-001 Parameter D_BIT, default 16, sample width in bits.
REQ-002 Parameter A_BIT, default 8, bank address width; BANK_SIZE = 2**A_BIT; N = 4*BANK_SIZE (default 1024).
REQ-003 Parameter START_TO, default 4, maximum cycles from oSTART pulse to iRDY going low.
REQ-004 iCLK  input  1  single clock; all logic on rising edge.
REQ-005 iRESET  input  1  asynchronous, active-low reset.
REQ-006 iDATA  input  D_BIT  input sample stream; iVALID input 1 sample valid; oREADY output 1 sequencer accepts.
REQ-007 oDATA  output  D_BIT  result stream; oVALID output 1 result valid; iREADY input 1 sink accepts.
REQ-008 oSTART  output  1  one-cycle start pulse to fht_control; iRDY input 1 fht_control ready (low = busy).
REQ-009 oADDR  output  A_BIT  shared bank address for load writes and unload reads.
REQ-010 oWDATA  output  D_BIT  bank write data; oWE_0..oWE_3 output 1 each, per-bank write enable.
REQ-011 iRDATA_0..iRDATA_3  input  D_BIT each  bank read data, valid one cycle after oADDR.
REQ-012 oBUSY  output  1  high in any state except IDLE; oERR output 1 sticky start-timeout flag.

Function
REQ-013 States: IDLE, LOAD, KICK, WAIT_BUSY, WAIT_RDY, UNLOAD, DRAIN; IDLE -> LOAD when iVALID=1.
REQ-014 LOAD: oREADY=1; each iVALID&oREADY writes sample k (0..N-1) to bank k[1:0] at address k[A_BIT+1:2], same cycle, exactly one oWE_x high.
REQ-015 After sample k=N-1 is accepted, oREADY drops next cycle and state -> KICK; no further input accepted until next IDLE.
REQ-016 KICK: oSTART=1 for exactly one cycle, then WAIT_BUSY.
REQ-017 WAIT_BUSY: iRDY=0 -> WAIT_RDY; if iRDY stays 1 for START_TO cycles, set oERR=1 and return to IDLE.
REQ-018 WAIT_RDY: wait for iRDY=1 (no timeout); then UNLOAD with read index j=0.
REQ-019 UNLOAD: issue read of result j from bank j[1:0], address j[A_BIT+1:2]; mux iRDATA of that bank one cycle later into a 2-entry output FIFO.
REQ-020 A read is issued only if FIFO occupancy plus in-flight reads < 2; no sample lost or duplicated under any iREADY pattern.
REQ-021 oDATA/oVALID driven from FIFO head; entry pops on oVALID&iREADY; oDATA stable while oVALID=1 and iREADY=0.
REQ-022 After read j=N-1 issued -> DRAIN; DRAIN -> IDLE when FIFO empty and no read in flight.
REQ-023 Results emitted in order j=0..N-1; throughput one result per cycle with iREADY held high.
REQ-024 Simultaneous push and pop on full FIFO permitted; occupancy unchanged.
REQ-025 iRDY transitions outside WAIT_BUSY/WAIT_RDY ignored; oERR cleared only by reset or next IDLE->LOAD.
REQ-026 oWE_x never asserted outside LOAD; oSTART never asserted outside KICK.

Reset
REQ-027 iRESET=0 forces, asynchronously: state IDLE, counters 0, FIFO empty, oREADY/oVALID/oSTART/oWE_x/oBUSY/oERR = 0, oADDR/oWDATA/oDATA = 0.
REQ-028 Reset mid-LOAD or mid-UNLOAD abandons the frame; after release, next iVALID starts a new frame at k=0.

Structure
REQ-029 State enum, N, BANK_SIZE and START_TO default shall live in shared package fht_pkg, deriving A_BIT/D_BIT from fht_defines.v.
REQ-030 Output FIFO shall be sub-module fht_skid_fifo (depth 2, D_BIT wide, push/pop/full/empty).

Verification
REQ-031 Stream 1024 samples value=k with iVALID=1 -> bank b written at address k>>2 for k%4=b, oSTART one pulse 1 cycle after last accept.
REQ-032 Model fht_control: iRDY low 2 cycles after oSTART, high 300 cycles later -> UNLOAD, oDATA = bank contents in order 0..1023, 1024 transfers.
REQ-033 iREADY random 50% during unload -> exactly 1024 results, in order, oDATA stable during stalls.
REQ-034 iRDY held high after oSTART -> oERR=1 after 4 cycles, state IDLE, no reads issued.
REQ-035 Assert iRESET=0 at k=500 of load -> all outputs 0 at once; new 1024-sample frame afterwards completes correctly.
REQ-036 iVALID toggling every cycle during load -> 1024 writes, no oWE_x on idle cycles, oREADY low after last sample.
